// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock detector.
//   state_t  : lock state machine encoding (IDLE, ARM, ACQUIRE, LOCKED)
//   *_DEF    : default parameter values for the detector
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int N_DEF          = 30;
  localparam int TOL_DEF        = 1;
  localparam int LOCK_CNT_DEF   = 8;
  localparam int UNLOCK_CNT_DEF = 2;
  localparam int TIMEOUT_DEF    = 60;
  localparam int CW_DEF         = 8;

endpackage

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference clock into the clk domain and flags
// its rising edges.
//   clk      in  : PLL output clock
//   rst_n    in  : asynchronous active-low reset
//   ref_in   in  : reference clock, asynchronous to clk
//   ref_edge out : one-cycle pulse per synchronized rising edge of ref_in
module ref_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_in,
  output logic ref_edge
);

  logic sync_p0;
  logic sync_p1;
  logic dly_p2;

  // Stage 0/1: two-flop synchronizer; stage 2: delay flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      dly_p2  <= 1'b0;
    end else begin
      sync_p0 <= ref_in;
      sync_p1 <= sync_p0;
      dly_p2  <= sync_p1;
    end
  end

  assign ref_edge = sync_p1 & ~dly_p2;

endmodule

// File: rtl/pll_lock_detect.sv
// Digital PLL lock detector, clocked by the PLL output. Counts clk cycles
// per reference period, compares each count with the divide ratio and runs
// a hysteretic lock state machine.
//   clk        in  : PLL output clock (only clock)
//   rst_n      in  : asynchronous active-low reset
//   en         in  : detector enable
//   ref_in     in  : reference clock, asynchronous
//   meas       out : cycles counted in the last completed window
//   meas_err   out : signed meas - N
//   meas_valid out : one-cycle pulse when meas/meas_err update
//   lock       out : high exactly while in LOCKED
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          ref_in,
  output logic [CW-1:0] meas,
  output logic [CW:0]   meas_err,
  output logic          meas_valid,
  output logic          lock
);

  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RW      = $clog2(RUN_MAX + 1);

  localparam logic [CW-1:0]        TIMEOUT_C = CW'(TIMEOUT);
  localparam logic signed [CW:0]   N_C       = (CW+1)'(N);
  localparam logic signed [CW:0]   TOL_C     = (CW+1)'(TOL);
  localparam logic [RW-1:0]        LOCK_C    = RW'(LOCK_CNT);
  localparam logic [RW-1:0]        UNLOCK_C  = RW'(UNLOCK_CNT);

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (v == {RW{1'b1}}) ? v : v + RW'(1);
  endfunction

  function automatic logic in_tol(input logic signed [CW:0] e);
    return (e >= -TOL_C) && (e <= TOL_C);
  endfunction

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [RW-1:0]       good_run, good_nxt, good_inc;
  logic [RW-1:0]       bad_run, bad_nxt, bad_inc;
  logic                mv_nxt;
  logic                ref_edge;
  logic                win_end;
  logic signed [CW:0]  err_p0;
  logic                good_p0;

  ref_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ref_in   (ref_in),
    .ref_edge (ref_edge)
  );

  // Stage 0: window end and evaluation of the count that just closed.
  // An edge coinciding with the timeout is one event with count TIMEOUT.
  assign win_end = ref_edge | (cnt == TIMEOUT_C);
  assign err_p0  = $signed({1'b0, cnt}) - N_C;
  assign good_p0 = in_tol(err_p0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    good_nxt  = good_run;
    bad_nxt   = bad_run;
    mv_nxt    = 1'b0;
    good_inc  = sat_inc(good_run);
    bad_inc   = sat_inc(bad_run);
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = ARM;
        end
        ARM: begin
          // The arming edge only starts the first window; no measurement.
          if (win_end) begin
            cnt_nxt = CW'(1);
            if (ref_edge) begin
              state_nxt = ACQUIRE;
              good_nxt  = '0;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ACQUIRE, LOCKED: begin
          if (win_end) begin
            cnt_nxt = CW'(1);
            mv_nxt  = 1'b1;
            if (state == ACQUIRE) begin
              if (good_p0) begin
                good_nxt = good_inc;
                if (good_inc >= LOCK_C) begin
                  state_nxt = LOCKED;
                  bad_nxt   = '0;
                end
              end else begin
                good_nxt = '0;
              end
            end else begin
              if (good_p0) begin
                bad_nxt = '0;
              end else begin
                bad_nxt = bad_inc;
                if (bad_inc >= UNLOCK_C) begin
                  state_nxt = ACQUIRE;
                  good_nxt  = '0;
                end
              end
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage 1: registered state, measurement and lock (lock moves with the pulse)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      good_run   <= '0;
      bad_run    <= '0;
      lock       <= 1'b0;
      meas_valid <= 1'b0;
      meas       <= '0;
      meas_err   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      good_run   <= good_nxt;
      bad_run    <= bad_nxt;
      lock       <= (state_nxt == LOCKED);
      meas_valid <= mv_nxt;
      if (mv_nxt) begin
        meas     <= cnt;
        meas_err <= err_p0;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_detect.sv
module tb_pll_lock_detect;

  localparam int N       = 30;
  localparam int TOL     = 1;
  localparam int LCK     = 8;
  localparam int ULCK    = 2;
  localparam int TIMEOUT = 60;
  localparam int CW      = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          ref_in = 1'b0;
  logic [CW-1:0] meas;
  logic [CW:0]   meas_err;
  logic          meas_valid;
  logic          lock;

  pll_lock_detect dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ref_in     (ref_in),
    .meas       (meas),
    .meas_err   (meas_err),
    .meas_valid (meas_valid),
    .lock       (lock)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Window-level model: each completed window yields one expected pulse
  typedef struct {
    int m;
    int err;
    bit lk;
    int gap;
  } exp_t;

  exp_t q[$];
  int   gr = 0;
  int   br = 0;
  bit   mlocked = 0;
  bit   first = 0;

  task automatic model_push(input int m);
    exp_t e;
    bit good;
    good = (m >= N - TOL) && (m <= N + TOL);
    if (!mlocked) begin
      if (good) begin
        gr++;
        if (gr >= LCK) begin mlocked = 1; br = 0; end
      end else gr = 0;
    end else begin
      if (good) br = 0;
      else begin
        br++;
        if (br >= ULCK) begin mlocked = 0; gr = 0; end
      end
    end
    e.m   = m;
    e.err = m - N;
    e.lk  = mlocked;
    e.gap = first ? 0 : m;
    first = 0;
    q.push_back(e);
  endtask

  // A gap of p cycles between reference edges: timeouts split it into windows
  task automatic model_gap(input int p);
    int r;
    r = p;
    while (r > TIMEOUT) begin
      model_push(TIMEOUT);
      r -= TIMEOUT;
    end
    model_push(r);
  endtask

  task automatic model_reset();
    gr = 0; br = 0; mlocked = 0;
    q.delete();
  endtask

  // Compare process: every cycle lock must equal the lock implied by the last
  // measurement; every pulse must match the next expected window.
  int  npulse = 0;
  bit  exp_lock = 0;
  bit  en_s;
  int  cyc = 0;
  int  last_cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      en_s = en;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_lock = 0;
        chk("lock_in_reset", {31'b0, lock}, 32'd0);
        continue;
      end
      if (!en_s) exp_lock = 0;
      if (meas_valid) begin
        npulse++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("meas", {24'b0, meas}, 32'(e.m));
          chk("meas_err", 32'($signed(meas_err)), 32'(e.err));
          if (e.gap != 0) chk("pulse_gap", 32'(cyc - last_cyc), 32'(e.gap));
          exp_lock = e.lk;
        end
        last_cyc = cyc;
      end
      chk("lock", {31'b0, lock}, {31'b0, exp_lock});
    end
  end

  // Stimulus timing in negedge counts; ref_in falls 10 cycles after each rise
  int scyc = 0;
  int rise_cyc = -100;

  task automatic tick();
    @(negedge clk);
    scyc++;
    if (scyc == rise_cyc + 10) ref_in = 1'b0;
  endtask

  task automatic wait_until(input int off);
    while (scyc < rise_cyc + off) tick();
  endtask

  task automatic arm_edge();
    tick();
    ref_in   = 1'b1;
    rise_cyc = scyc;
    first    = 1;
  endtask

  task automatic next_edge(input int p);
    model_gap(p);
    wait_until(p);
    ref_in   = 1'b1;
    rise_cyc = scyc;
  endtask

  // Edge after p cycles, then hand-computed expectations for that window
  task automatic edge_lit(input int p, input int err, input bit lk);
    next_edge(p);
    wait_until(5);
    chk("lit_meas", {24'b0, meas}, 32'(p));
    chk("lit_err", 32'($signed(meas_err)), 32'(err));
    chk("lit_lock", {31'b0, lock}, {31'b0, lk});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state: outputs clear without any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_lock", {31'b0, lock}, 32'd0);
    chk("rst_meas", {24'b0, meas}, 32'd0);
    chk("rst_err", {23'b0, meas_err}, 32'd0);
    chk("rst_valid", {31'b0, meas_valid}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Exact period: arm edge, then lock on the 8th measurement
    en = 1'b1;
    repeat (3) tick();
    arm_edge();
    wait_until(5);
    chk("arm_no_pulse", 32'(npulse), 32'd0);
    for (int i = 0; i < 7; i++) next_edge(30);
    wait_until(5);
    chk("pulses_7", 32'(npulse), 32'd7);
    chk("lock_7", {31'b0, lock}, 32'd0);
    chk("meas_30", {24'b0, meas}, 32'd30);
    chk("err_30", {23'b0, meas_err}, 32'd0);
    next_edge(30);
    wait_until(5);
    chk("pulses_8", 32'(npulse), 32'd8);
    chk("lock_8", {31'b0, lock}, 32'd1);

    // Tolerance around N while locked
    edge_lit(31, 1, 1);
    edge_lit(29, -1, 1);
    chk("err_neg_raw", {23'b0, meas_err}, 32'h1FF);
    edge_lit(33, 3, 1);
    edge_lit(30, 0, 1);
    edge_lit(33, 3, 1);
    edge_lit(33, 3, 0);
    for (int i = 0; i < 8; i++) next_edge(30);
    wait_until(5);
    chk("relock_tol", {31'b0, lock}, 32'd1);

    // Reference stall: timeouts at 60 and 120 cycles, lock drops on the 2nd
    model_gap(150);
    wait_until(70);
    chk("stall1_meas", {24'b0, meas}, 32'd60);
    chk("stall1_err", 32'($signed(meas_err)), 32'd30);
    chk("stall1_lock", {31'b0, lock}, 32'd1);
    wait_until(130);
    chk("stall2_meas", {24'b0, meas}, 32'd60);
    chk("stall2_lock", {31'b0, lock}, 32'd0);
    wait_until(150);
    ref_in   = 1'b1;
    rise_cyc = scyc;
    for (int i = 0; i < 8; i++) next_edge(30);
    wait_until(5);
    chk("relock_stall", {31'b0, lock}, 32'd1);

    // Edge coinciding with timeout: one pulse, next window restarts at 1
    base = npulse;
    edge_lit(60, 30, 1);
    chk("coinc_one", 32'(npulse - base), 32'd1);
    edge_lit(30, 0, 1);

    // Enable drop while locked
    wait_until(20);
    en = 1'b0;
    model_reset();
    tick();
    chk("endrop_lock", {31'b0, lock}, 32'd0);
    base = npulse;
    repeat (80) tick();
    chk("endrop_quiet", 32'(npulse - base), 32'd0);
    en = 1'b1;
    repeat (3) tick();
    arm_edge();
    for (int i = 0; i < 7; i++) next_edge(30);
    wait_until(5);
    chk("reen_lock_7", {31'b0, lock}, 32'd0);
    next_edge(30);
    wait_until(5);
    chk("reen_lock_8", {31'b0, lock}, 32'd1);

    // Async reset mid-ACQUIRE, between clock edges
    wait_until(20);
    en = 1'b0;
    tick();
    model_reset();
    en = 1'b1;
    repeat (3) tick();
    arm_edge();
    for (int i = 0; i < 3; i++) next_edge(30);
    wait_until(20);
    chk("pre_rst_meas", {24'b0, meas}, 32'd30);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lock", {31'b0, lock}, 32'd0);
    chk("arst_meas", {24'b0, meas}, 32'd0);
    chk("arst_err", {23'b0, meas_err}, 32'd0);
    chk("arst_valid", {31'b0, meas_valid}, 32'd0);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    arm_edge();
    for (int i = 0; i < 8; i++) next_edge(30);
    wait_until(20);
    chk("post_rst_lock", {31'b0, lock}, 32'd1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
